// File: rtl/hit_detection.sv
// hit_detection: per-pixel collision detector for player, enemy and missile objects.
// Compares the drawing requests of all objects on the current pixel and emits
// registered collision bits. Types selected by ONE_SHOT_MASK fire at most once per
// frame; the rest follow every overlapping pixel. A sticky OR of all emitted
// collisions is handed to frame_summary at each start of frame.
module hit_detection #(
    parameter int                         COLLISION_WIDTH = 8,
    parameter logic [COLLISION_WIDTH-1:0] ONE_SHOT_MASK   = 8'b1101_1110
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       startOfFrame,
    input  logic                       player_dr,
    input  logic                       player_missile_dr,
    input  logic                       enemy_dr,
    input  logic                       enemy_missile_dr,
    input  logic                       boundary_dr,
    input  logic                       far_boundary_dr,
    output logic [COLLISION_WIDTH-1:0] collision,
    output logic [COLLISION_WIDTH-1:0] frame_summary
);

    // Raw overlaps on the current pixel (forced to zero while the game is frozen).
    logic [COLLISION_WIDTH-1:0] raw;
    // Per-type "already fired this frame" flags; only one-shot bits ever set.
    logic [COLLISION_WIDTH-1:0] fired_flag;
    // Flags as seen this cycle: a start of frame clears them before evaluation.
    logic [COLLISION_WIDTH-1:0] eff_flag;
    // Collision bits that will be registered onto the output this cycle.
    logic [COLLISION_WIDTH-1:0] pulse;
    // Sticky OR of emitted collisions since the last start of frame.
    logic [COLLISION_WIDTH-1:0] accumulator;

    // Raw pairwise overlap map for the current pixel.
    always_comb begin
        raw = '0;
        if (enable) begin
            raw[0] = player_dr         & boundary_dr;
            raw[1] = player_dr         & enemy_missile_dr;
            raw[2] = player_dr         & enemy_dr;
            raw[3] = enemy_dr          & player_missile_dr;
            raw[4] = player_missile_dr & far_boundary_dr;
            raw[5] = enemy_dr          & boundary_dr;
            raw[6] = enemy_missile_dr  & far_boundary_dr;
            raw[7] = player_missile_dr & enemy_missile_dr;
        end else begin
            raw = '0;
        end
    end

    // One-shot qualification: frame clear wins, then the event sees the cleared flag.
    always_comb begin
        eff_flag = fired_flag;
        if (startOfFrame) begin
            eff_flag = '0;
        end else begin
            eff_flag = fired_flag;
        end
        pulse = raw & ~(ONE_SHOT_MASK & eff_flag);
    end

    // Output register, fired flags, accumulator and per-frame summary.
    always_ff @(posedge clk) begin
        if (reset) begin
            collision     <= '0;
            frame_summary <= '0;
            fired_flag    <= '0;
            accumulator   <= '0;
        end else begin
            collision  <= pulse;
            fired_flag <= eff_flag | (pulse & ONE_SHOT_MASK);
            if (startOfFrame) begin
                // Summary gets the finished frame; the new frame starts with this cycle's events.
                frame_summary <= accumulator;
                accumulator   <= pulse;
            end else begin
                accumulator   <= accumulator | pulse;
            end
        end
    end

endmodule

// File: tb/tb_hit_detection.sv
// Self-checking bench for hit_detection: directed scenarios plus randomized
// stimulus compared against a frame-level behavioural reference model.
module tb_hit_detection;

    localparam int W = 8;
    localparam logic [W-1:0] MASK = 8'b1101_1110;

    // Drawing-request vector positions used by the bench.
    localparam logic [5:0] P   = 6'b000001; // player
    localparam logic [5:0] PM  = 6'b000010; // player missile
    localparam logic [5:0] E   = 6'b000100; // enemy
    localparam logic [5:0] EM  = 6'b001000; // enemy missile
    localparam logic [5:0] B   = 6'b010000; // boundary
    localparam logic [5:0] FB  = 6'b100000; // far boundary
    localparam logic [5:0] ALL = 6'b111111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         startOfFrame = 1'b0;
    logic [5:0]   dr = 6'd0;
    logic [W-1:0] collision;
    logic [W-1:0] frame_summary;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: which one-shot types already hit in this frame,
    // which types were reported this frame, and the expected outputs.
    bit           seen_once [W];
    logic [W-1:0] frame_hits;
    logic [W-1:0] exp_coll;
    logic [W-1:0] exp_sum;

    // Pair table: collision type k is the overlap of objects pa[k] and pb[k].
    int pa [W] = '{0, 0, 0, 2, 1, 2, 3, 1};
    int pb [W] = '{4, 3, 2, 1, 5, 4, 5, 3};

    hit_detection #(.COLLISION_WIDTH(W), .ONE_SHOT_MASK(MASK)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .startOfFrame      (startOfFrame),
        .player_dr         (dr[0]),
        .player_missile_dr (dr[1]),
        .enemy_dr          (dr[2]),
        .enemy_missile_dr  (dr[3]),
        .boundary_dr       (dr[4]),
        .far_boundary_dr   (dr[5]),
        .collision         (collision),
        .frame_summary     (frame_summary)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference model by one pixel clock.
    task automatic model_tick();
        logic [W-1:0] now;
        now = '0;
        if (reset) begin
            for (int k = 0; k < W; k++) seen_once[k] = 1'b0;
            frame_hits = '0;
            exp_coll   = '0;
            exp_sum    = '0;
        end else begin
            if (startOfFrame)
                for (int k = 0; k < W; k++) seen_once[k] = 1'b0;
            for (int k = 0; k < W; k++) begin
                if (enable && dr[pa[k]] && dr[pb[k]]) begin
                    if (!MASK[k]) begin
                        now[k] = 1'b1;
                    end else if (!seen_once[k]) begin
                        now[k] = 1'b1;
                        seen_once[k] = 1'b1;
                    end
                end
            end
            if (startOfFrame) begin
                exp_sum    = frame_hits;
                frame_hits = now;
            end else begin
                frame_hits = frame_hits | now;
            end
            exp_coll = now;
        end
    endtask

    // Drive one pixel's inputs, clock it, and compare both outputs to the model.
    task automatic step(input logic [5:0] d, input logic sof, input logic en, input logic rst);
        dr           = d;
        startOfFrame = sof;
        enable       = en;
        reset        = rst;
        @(posedge clk);
        model_tick();
        #1;
        check("collision", collision, exp_coll);
        check("frame_summary", frame_summary, exp_sum);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset then idle.
        step(6'd0, 1'b0, 1'b0, 1'b1);
        step(6'd0, 1'b0, 1'b0, 1'b1);
        check("reset_coll", collision, 8'h00);
        check("reset_sum", frame_summary, 8'h00);
        step(6'd0, 1'b1, 1'b1, 1'b0);
        step(6'd0, 1'b0, 1'b1, 1'b0);
        check("idle_coll", collision, 8'h00);

        // Player hit by enemy missile for 5 pixels: one pulse only.
        for (int i = 0; i < 5; i++) begin
            step(P | EM, 1'b0, 1'b1, 1'b0);
            check("oneshot_b1", collision, (i == 0) ? 8'h02 : 8'h00);
        end
        // Player on boundary for 3 pixels: pass-through every pixel.
        for (int i = 0; i < 3; i++) begin
            step(P | B, 1'b0, 1'b1, 1'b0);
            check("pass_b0", collision, 8'h01);
        end
        step(6'd0, 1'b0, 1'b1, 1'b0);
        check("pass_b0_end", collision, 8'h00);

        // New frame: summary of bits 0 and 1.
        step(6'd0, 1'b1, 1'b1, 1'b0);
        check("sum_b0b1", frame_summary, 8'h03);
        // Bit 3 in this frame, then again coincident with the next start of frame.
        step(E | PM, 1'b0, 1'b1, 1'b0);
        check("b3_fire", collision, 8'h08);
        step(E | PM, 1'b0, 1'b1, 1'b0);
        check("b3_suppr", collision, 8'h00);
        step(E | PM, 1'b1, 1'b1, 1'b0);
        check("sof_b3_coll", collision, 8'h08);
        check("sof_b3_sum", frame_summary, 8'h08);
        step(6'd0, 1'b0, 1'b1, 1'b0);
        // The coincident event belongs to the new frame.
        step(6'd0, 1'b1, 1'b1, 1'b0);
        check("sum_carry_b3", frame_summary, 8'h08);
        step(6'd0, 1'b0, 1'b1, 1'b0);
        step(6'd0, 1'b1, 1'b1, 1'b0);
        check("sum_quiet", frame_summary, 8'h00);

        // Enable gating: bit 2 fires, freeze with every object overlapping, then resume.
        step(P | E, 1'b0, 1'b1, 1'b0);
        check("b2_fire", collision, 8'h04);
        for (int i = 0; i < 3; i++) begin
            step(ALL, 1'b0, 1'b0, 1'b0);
            check("frozen", collision, 8'h00);
        end
        step(ALL, 1'b0, 1'b1, 1'b0);
        check("resume_all", collision, 8'hFB);
        step(ALL, 1'b0, 1'b1, 1'b0);
        check("resume_pass", collision, 8'h21);
        step(FB | EM, 1'b0, 1'b1, 1'b0);
        check("b6_suppr", collision, 8'h00);
        step(6'd0, 1'b1, 1'b0, 1'b0);
        check("sum_frozen_sof", frame_summary, 8'hFF);

        // Mid-frame reset overrides everything.
        step(ALL, 1'b1, 1'b1, 1'b1);
        check("midreset_coll", collision, 8'h00);
        check("midreset_sum", frame_summary, 8'h00);

        // Randomized traffic with short frames.
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] d;
            for (int j = 0; j < 6; j++) d[j] = ($urandom_range(0, 99) < 35);
            step(d,
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
